// File: rtl/vga_console_term_ctrl.sv
// Terminal-style write sequencer for the VGA console text buffer: turns a byte
// stream into character writes, cursor motion, line scroll and screen clear.
module vga_console_term_ctrl #(
   parameter int NUM_ROWS = 3,
   parameter int NUM_COLS = 10,
   parameter int ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              color_sel,
   output logic              in_ready,
   output logic              busy,
   input  logic              wr_allow,
   output logic              buf_we,
   output logic [ADDR_W-1:0] buf_waddr,
   output logic [7:0]        buf_wdata,
   output logic [ADDR_W-1:0] buf_raddr,
   input  logic [7:0]        buf_rdata,
   output logic [1:0]        cursor_row,
   output logic [3:0]        cursor_col
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUT,
      S_SCROLL_COPY,
      S_SCROLL_CLEAR,
      S_CLEAR_ALL
   } state_t;

   localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(NUM_COLS);
   localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
   localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(NUM_COLS - 1);
   localparam logic [ADDR_W-1:0] ALL_LAST  = ADDR_W'(NUM_ROWS * NUM_COLS - 1);
   localparam logic [1:0]        LAST_ROW  = 2'(NUM_ROWS - 1);
   localparam logic [3:0]        LAST_COL  = 4'(NUM_COLS - 1);
   localparam logic [7:0]        FILL      = 8'h20;

   state_t            state_q, state_d;
   logic [7:0]        op_q, op_d;
   logic              color_q, color_d;
   logic [1:0]        row_q, row_d;
   logic [3:0]        col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   logic op_print, op_lf, op_cr, op_bs, op_ff;
   logic col_nz, put_wr, write_state, commit;
   logic [ADDR_W-1:0] col_ext;

   assign op_print = ~op_q[7] && (op_q[6:0] >= 7'h20) && (op_q[6:0] != 7'h7F);
   assign op_lf    = (op_q == 8'h0A);
   assign op_cr    = (op_q == 8'h0D);
   assign op_bs    = (op_q == 8'h08);
   assign op_ff    = (op_q == 8'h0C);
   assign col_nz   = (col_q != 4'd0);
   assign col_ext  = ADDR_W'(col_q);

   // Only printable chars and a backspace that actually moves need a buffer slot.
   assign put_wr      = (state_q == S_PUT) && (op_print || (op_bs && col_nz));
   assign write_state = put_wr || (state_q == S_SCROLL_COPY) ||
                        (state_q == S_SCROLL_CLEAR) || (state_q == S_CLEAR_ALL);
   assign commit      = write_state && wr_allow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 8'h00;
         color_q <= 1'b0;
         row_q   <= 2'd0;
         col_q   <= 4'd0;
         addr_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         color_q <= color_d;
         row_q   <= row_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      color_d = color_q;
      row_d   = row_q;
      col_d   = col_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = in_data;
               color_d = color_sel;
               state_d = S_PUT;
            end
         end
         S_PUT: begin
            if (op_print) begin
               if (wr_allow) begin
                  state_d = S_IDLE;
                  if (col_q == LAST_COL) begin
                     col_d = 4'd0;
                     if (row_q == LAST_ROW) begin
                        addr_d  = LAST_BASE;
                        idx_d   = '0;
                        state_d = S_SCROLL_COPY;
                     end else begin
                        row_d  = row_q + 2'd1;
                        addr_d = addr_q + 1'b1;
                     end
                  end else begin
                     col_d  = col_q + 4'd1;
                     addr_d = addr_q + 1'b1;
                  end
               end
            end else if (op_lf) begin
               col_d   = 4'd0;
               state_d = S_IDLE;
               if (row_q == LAST_ROW) begin
                  addr_d  = LAST_BASE;
                  idx_d   = '0;
                  state_d = S_SCROLL_COPY;
               end else begin
                  row_d  = row_q + 2'd1;
                  addr_d = addr_q - col_ext + COLS_A;
               end
            end else if (op_cr) begin
               col_d   = 4'd0;
               addr_d  = addr_q - col_ext;
               state_d = S_IDLE;
            end else if (op_bs && col_nz) begin
               if (wr_allow) begin
                  col_d   = col_q - 4'd1;
                  addr_d  = addr_q - 1'b1;
                  state_d = S_IDLE;
               end
            end else if (op_ff) begin
               idx_d   = '0;
               state_d = S_CLEAR_ALL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCROLL_COPY: begin
            if (wr_allow) begin
               if (idx_q == COPY_LAST) begin
                  idx_d   = '0;
                  state_d = S_SCROLL_CLEAR;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_SCROLL_CLEAR: begin
            if (wr_allow) begin
               if (idx_q == ROW_LAST) begin
                  idx_d   = '0;
                  row_d   = LAST_ROW;
                  col_d   = 4'd0;
                  addr_d  = LAST_BASE;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_CLEAR_ALL: begin
            if (wr_allow) begin
               if (idx_q == ALL_LAST) begin
                  idx_d   = '0;
                  row_d   = 2'd0;
                  col_d   = 4'd0;
                  addr_d  = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Copy reads one row ahead of where it writes, so source is never clobbered.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      buf_we    = commit;
      buf_raddr = idx_q + COLS_A;
      buf_waddr = idx_q;
      buf_wdata = FILL;
      case (state_q)
         S_PUT: begin
            if (op_print) begin
               buf_waddr = addr_q;
               buf_wdata = {color_q, op_q[6:0]};
            end else begin
               buf_waddr = addr_q - 1'b1;
               buf_wdata = FILL;
            end
         end
         S_SCROLL_COPY: begin
            buf_waddr = idx_q;
            buf_wdata = buf_rdata;
         end
         S_SCROLL_CLEAR: begin
            buf_waddr = LAST_BASE + idx_q;
            buf_wdata = FILL;
         end
         S_CLEAR_ALL: begin
            buf_waddr = idx_q;
            buf_wdata = FILL;
         end
         default: begin
            buf_waddr = idx_q;
            buf_wdata = FILL;
         end
      endcase
   end

   assign cursor_row = row_q;
   assign cursor_col = col_q;

endmodule

// File: tb/tb_vga_console_term_ctrl.sv
// Directed bench for vga_console_term_ctrl with a behavioural text RAM and write log.
module tb_vga_console_term_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       color_sel;
   logic       in_ready;
   logic       busy;
   logic       wr_allow;
   logic       buf_we;
   logic [4:0] buf_waddr;
   logic [7:0] buf_wdata;
   logic [4:0] buf_raddr;
   logic [7:0] buf_rdata;
   logic [1:0] cursor_row;
   logic [3:0] cursor_col;

   int tests_run = 0;
   int fails     = 0;

   logic [7:0] mem [0:31];
   logic [4:0] log_a [$];
   logic [7:0] log_d [$];

   always #5 clk = ~clk;

   assign buf_rdata = mem[buf_raddr];

   always @(posedge clk) begin
      if (buf_we === 1'b1) begin
         mem[buf_waddr] <= buf_wdata;
         log_a.push_back(buf_waddr);
         log_d.push_back(buf_wdata);
      end
   end

   vga_console_term_ctrl #(.NUM_ROWS(3), .NUM_COLS(10), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .color_sel  (color_sel),
      .in_ready   (in_ready),
      .busy       (busy),
      .wr_allow   (wr_allow),
      .buf_we     (buf_we),
      .buf_waddr  (buf_waddr),
      .buf_wdata  (buf_wdata),
      .buf_raddr  (buf_raddr),
      .buf_rdata  (buf_rdata),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col)
   );

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input bit toggle);
      int c;
      c = 0;
      #1;
      while (in_ready !== 1'b1 && c < 500) begin
         @(negedge clk);
         if (toggle) wr_allow = ~wr_allow;
         #1;
         c++;
      end
      wr_allow = 1'b1;
      tests_run++;
      if (c >= 500) begin
         fails++;
         $display("FAIL wait_idle: in_ready=%b after %0d cycles, required 1", in_ready, c);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit toggle);
      @(negedge clk);
      in_valid = 1'b1; in_data = b;
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle(toggle);
   endtask

   task automatic test_reset();
      wr_allow = 1'b1; color_sel = 1'b0; in_data = 8'h00;
      do_reset();
      #1;
      tests_run++;
      if ({in_ready, busy, buf_we} !== 3'b100) begin
         fails++;
         $display("FAIL reset_flags: ready/busy/we=%b required 100", {in_ready, busy, buf_we});
      end
      tests_run++;
      if ({cursor_row, cursor_col} !== 6'd0) begin
         fails++;
         $display("FAIL reset_cursor: (%0d,%0d) required (0,0)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_single_char();
      int base;
      base = log_a.size();
      color_sel = 1'b1; wr_allow = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h41;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL t1_accept_ready: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests_run++;
      if ({in_ready, buf_we, buf_waddr, buf_wdata} !== {1'b0, 1'b1, 5'd0, 8'hC1}) begin
         fails++;
         $display("FAIL t1_write: ready=%b we=%b waddr=%0d wdata=%h required 0 1 0 c1",
                  in_ready, buf_we, buf_waddr, buf_wdata);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if ({in_ready, cursor_row, cursor_col} !== {1'b1, 2'd0, 4'd1}) begin
         fails++;
         $display("FAIL t1_done: ready=%b cursor=(%0d,%0d) required 1 (0,1)",
                  in_ready, cursor_row, cursor_col);
      end
      tests_run++;
      if (log_a.size() - base !== 1) begin
         fails++; $display("FAIL t1_count: %0d writes required 1", log_a.size() - base);
      end
      color_sel = 1'b0;
   endtask

   task automatic test_stall();
      int base;
      int bad;
      base = log_a.size();
      bad = 0;
      @(negedge clk);
      wr_allow = 1'b0; in_valid = 1'b1; in_data = 8'h42;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (buf_we !== 1'b0 || in_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      tests_run++;
      if (bad !== 0) begin
         fails++; $display("FAIL t2_stall: %0d bad stalled cycles required 0", bad);
      end
      wr_allow = 1'b1;
      #1;
      tests_run++;
      if ({buf_we, buf_waddr, buf_wdata} !== {1'b1, 5'd1, 8'h42}) begin
         fails++;
         $display("FAIL t2_write: we=%b waddr=%0d wdata=%h required 1 1 42",
                  buf_we, buf_waddr, buf_wdata);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if ({in_ready, cursor_row, cursor_col, 6'(log_a.size() - base)} !==
          {1'b1, 2'd0, 4'd2, 6'd1}) begin
         fails++;
         $display("FAIL t2_done: ready=%b cursor=(%0d,%0d) writes=%0d required 1 (0,2) 1",
                  in_ready, cursor_row, cursor_col, log_a.size() - base);
      end
   endtask

   task automatic test_wrap_scroll();
      int base;
      int n;
      logic [4:0] ea;
      logic [7:0] ed;
      do_reset();
      base = log_a.size();
      for (int i = 0; i < 30; i++) send(8'(8'h41 + i), 1'b0);
      n = log_a.size() - base;
      tests_run++;
      if (n !== 60) begin
         fails++; $display("FAIL t3_count: %0d writes required 60", n);
      end
      for (int i = 0; i < 60; i++) begin
         if (i < 30) begin
            ea = 5'(i); ed = 8'(8'h41 + i);
         end else if (i < 50) begin
            ea = 5'(i - 30); ed = 8'(8'h41 + i - 30 + 10);
         end else begin
            ea = 5'(20 + i - 50); ed = 8'h20;
         end
         if (i < n) begin
            tests_run++;
            if (log_a[base+i] !== ea || log_d[base+i] !== ed) begin
               fails++;
               $display("FAIL t3_write[%0d]: addr=%0d data=%h required %0d %h",
                        i, log_a[base+i], log_d[base+i], ea, ed);
            end
         end
      end
      tests_run++;
      if ({cursor_row, cursor_col} !== {2'd2, 4'd0}) begin
         fails++;
         $display("FAIL t3_cursor: (%0d,%0d) required (2,0)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_lf_cr();
      int base;
      int n;
      logic [4:0] ea;
      logic [7:0] ed;
      for (int i = 0; i < 4; i++) send(8'(8'h30 + i), 1'b0);
      tests_run++;
      if ({cursor_row, cursor_col} !== {2'd2, 4'd4}) begin
         fails++;
         $display("FAIL t4_pre: (%0d,%0d) required (2,4)", cursor_row, cursor_col);
      end
      base = log_a.size();
      send(8'h0A, 1'b0);
      n = log_a.size() - base;
      tests_run++;
      if (n !== 30) begin
         fails++; $display("FAIL t4_lf_count: %0d writes required 30", n);
      end
      for (int i = 0; i < 30; i++) begin
         ea = 5'(i);
         if (i < 10)      ed = 8'(8'h55 + i);
         else if (i < 14) ed = 8'(8'h30 + i - 10);
         else             ed = 8'h20;
         if (i < n) begin
            tests_run++;
            if (log_a[base+i] !== ea || log_d[base+i] !== ed) begin
               fails++;
               $display("FAIL t4_lf_write[%0d]: addr=%0d data=%h required %0d %h",
                        i, log_a[base+i], log_d[base+i], ea, ed);
            end
         end
      end
      tests_run++;
      if ({cursor_row, cursor_col} !== {2'd2, 4'd0}) begin
         fails++;
         $display("FAIL t4_lf_cursor: (%0d,%0d) required (2,0)", cursor_row, cursor_col);
      end
      do_reset();
      send(8'h0A, 1'b0);
      for (int i = 0; i < 5; i++) send(8'(8'h61 + i), 1'b0);
      tests_run++;
      if ({cursor_row, cursor_col} !== {2'd1, 4'd5}) begin
         fails++;
         $display("FAIL t4_cr_pre: (%0d,%0d) required (1,5)", cursor_row, cursor_col);
      end
      base = log_a.size();
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h0D;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      tests_run++;
      if ({busy, buf_we} !== 2'b10) begin
         fails++; $display("FAIL t4_cr_busy: busy/we=%b required 10", {busy, buf_we});
      end
      @(negedge clk);
      #1;
      tests_run++;
      if ({busy, cursor_row, cursor_col, 6'(log_a.size() - base)} !==
          {1'b0, 2'd1, 4'd0, 6'd0}) begin
         fails++;
         $display("FAIL t4_cr_done: busy=%b cursor=(%0d,%0d) writes=%0d required 0 (1,0) 0",
                  busy, cursor_row, cursor_col, log_a.size() - base);
      end
   endtask

   task automatic test_bs_ignore();
      int base;
      do_reset();
      base = log_a.size();
      send(8'h08, 1'b0);
      tests_run++;
      if ({cursor_row, cursor_col, 6'(log_a.size() - base)} !== {2'd0, 4'd0, 6'd0}) begin
         fails++;
         $display("FAIL t5_bs_col0: cursor=(%0d,%0d) writes=%0d required (0,0) 0",
                  cursor_row, cursor_col, log_a.size() - base);
      end
      for (int i = 0; i < 3; i++) send(8'(8'h58 + i), 1'b0);
      base = log_a.size();
      color_sel = 1'b1;
      send(8'h08, 1'b0);
      color_sel = 1'b0;
      tests_run++;
      if (log_a.size() - base !== 1) begin
         fails++; $display("FAIL t5_bs_count: %0d writes required 1", log_a.size() - base);
      end else begin
         tests_run++;
         if (log_a[base] !== 5'd2 || log_d[base] !== 8'h20) begin
            fails++;
            $display("FAIL t5_bs_write: addr=%0d data=%h required 2 20", log_a[base], log_d[base]);
         end
      end
      tests_run++;
      if ({cursor_row, cursor_col} !== {2'd0, 4'd2}) begin
         fails++;
         $display("FAIL t5_bs_cursor: (%0d,%0d) required (0,2)", cursor_row, cursor_col);
      end
      base = log_a.size();
      send(8'h07, 1'b0);
      send(8'h85, 1'b0);
      tests_run++;
      if ({cursor_row, cursor_col, 6'(log_a.size() - base)} !== {2'd0, 4'd2, 6'd0}) begin
         fails++;
         $display("FAIL t5_ignored: cursor=(%0d,%0d) writes=%0d required (0,2) 0",
                  cursor_row, cursor_col, log_a.size() - base);
      end
   endtask

   task automatic test_clear_and_abort();
      int base;
      int n;
      base = log_a.size();
      send(8'h0C, 1'b1);
      n = log_a.size() - base;
      tests_run++;
      if (n !== 30) begin
         fails++; $display("FAIL t6_ff_count: %0d writes required 30", n);
      end
      for (int i = 0; i < 30; i++) begin
         if (i < n) begin
            tests_run++;
            if (log_a[base+i] !== 5'(i) || log_d[base+i] !== 8'h20) begin
               fails++;
               $display("FAIL t6_ff_write[%0d]: addr=%0d data=%h required %0d 20",
                        i, log_a[base+i], log_d[base+i], i);
            end
         end
      end
      tests_run++;
      if ({cursor_row, cursor_col} !== {2'd0, 4'd0}) begin
         fails++;
         $display("FAIL t6_ff_cursor: (%0d,%0d) required (0,0)", cursor_row, cursor_col);
      end
      send(8'h0A, 1'b0);
      send(8'h0A, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h0A;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) @(negedge clk);
      #1;
      tests_run++;
      if ({busy, buf_we, cursor_row} !== {1'b1, 1'b1, 2'd2}) begin
         fails++;
         $display("FAIL t6_mid_scroll: busy/we=%b row=%0d required 11 2",
                  {busy, buf_we}, cursor_row);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({buf_we, in_ready, busy, cursor_row, cursor_col} !== {3'b010, 6'd0}) begin
         fails++;
         $display("FAIL t6_abort: we/ready/busy=%b cursor=(%0d,%0d) required 010 (0,0)",
                  {buf_we, in_ready, busy}, cursor_row, cursor_col);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; color_sel = 1'b0; wr_allow = 1'b1;
      test_reset();
      test_single_char();
      test_stall();
      test_wrap_scroll();
      test_lf_cr();
      test_bs_ignore();
      test_clear_and_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
